// File: rtl/fc_feed_sched.sv
// Frame scheduler feeding the 4-lane FC accumulator from the pooled feature buffer.
// Reads 4 channel groups per position, never ahead of the pooling stage, then waits for the logit.
module fc_feed_sched #(
  parameter int FEAT_W = 32,
  parameter int N_POS  = 169,
  parameter int N_GRP  = 4,
  parameter int POS_W  = 8
) (
  input  logic                  iClk,
  input  logic                  iRstn,
  input  logic                  iStart,
  input  logic                  iAbort,
  input  logic [POS_W:0]        iAvailPos,
  output logic                  oRdEn,
  output logic [POS_W-1:0]      oRdPos,
  output logic [1:0]            oRdGrp,
  input  logic [4*FEAT_W-1:0]   iRdData,
  output logic                  oFrameStart,
  output logic [3:0]            oValid4,
  output logic [FEAT_W-1:0]     oData0,
  output logic [FEAT_W-1:0]     oData1,
  output logic [FEAT_W-1:0]     oData2,
  output logic [FEAT_W-1:0]     oData3,
  output logic [1:0]            oPhase_g,
  input  logic                  iLogitValid,
  output logic                  oBusy,
  output logic                  oDone
);

  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [1:0]       LAST_GRP  = 2'(N_GRP - 1);
  localparam logic [POS_W:0]   AVAIL_MAX = (POS_W + 1)'(N_POS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FSTART,
    S_RUN,
    S_DRAIN,
    S_WAITL
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   w_pos_next;
  logic [1:0]         r_grp;
  logic [1:0]         w_grp_next;
  logic               r_valid;
  logic [1:0]         r_phase;
  logic               r_done;
  logic [POS_W:0]     w_avail;
  logic               w_rd_en;
  logic               w_issue;
  logic               w_done_next;
  logic [FEAT_W-1:0]  w_lane [4];

  // Counts above the frame size are treated as a fully written buffer.
  assign w_avail = (iAvailPos > AVAIL_MAX) ? AVAIL_MAX : iAvailPos;
  assign w_rd_en = (r_state == S_RUN) && ({1'b0, r_pos} < w_avail);
  // A read issued in the abort cycle is never presented to the FC.
  assign w_issue = w_rd_en && !iAbort;
  assign w_done_next = (r_state == S_WAITL) && iLogitValid && !iAbort;

  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_grp_next   = r_grp;
    case (r_state)
      S_IDLE: begin
        w_pos_next = '0;
        w_grp_next = '0;
        if (iStart) w_state_next = S_FSTART;
      end
      S_FSTART: w_state_next = S_RUN;
      S_RUN: begin
        if (w_rd_en) begin
          if ((r_pos == LAST_POS) && (r_grp == LAST_GRP)) begin
            w_state_next = S_DRAIN;
          end else if (r_grp == LAST_GRP) begin
            w_grp_next = '0;
            w_pos_next = r_pos + POS_ONE;
          end else begin
            w_grp_next = r_grp + 2'd1;
          end
        end
      end
      S_DRAIN: w_state_next = S_WAITL;
      S_WAITL: begin
        if (iLogitValid) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (iAbort) w_state_next = S_IDLE;
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_grp   <= '0;
      r_valid <= 1'b0;
      r_phase <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pos   <= w_pos_next;
      r_grp   <= w_grp_next;
      r_valid <= w_issue;
      r_done  <= w_done_next;
      // Phase holds through stalls so the FC sees a stable group index.
      if (w_issue) r_phase <= r_grp;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = r_valid ? iRdData[gi*FEAT_W +: FEAT_W] : '0;
    end
  endgenerate

  assign oData0      = w_lane[0];
  assign oData1      = w_lane[1];
  assign oData2      = w_lane[2];
  assign oData3      = w_lane[3];
  assign oRdEn       = w_rd_en;
  assign oRdPos      = r_pos;
  assign oRdGrp      = r_grp;
  assign oValid4     = {4{r_valid}};
  assign oPhase_g    = r_phase;
  assign oFrameStart = (r_state == S_FSTART);
  assign oBusy       = (r_state != S_IDLE);
  assign oDone       = r_done;

endmodule
